regs_wb_arb: RTL and testbench

//  Shares the register file's single write port (rda/rd/rdw) between the execute stage and the load unit.

---
 rtl/regs_pkg.sv | 21 ++
 rtl/regs_wb_fifo.sv | 52 +++++
 rtl/regs_wb_arb.sv | 115 +++++++++++
 tb/tb_regs_wb_arb.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// Shared types and constants for the register file write-back path.
package regs_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xword_t;

    typedef struct packed {
        reg_addr_t addr;
        xword_t    data;
    } ld_entry_t;

    function automatic logic [NREGS-1:0] reg_onehot(input reg_addr_t a);
        reg_onehot    = '0;
        reg_onehot[a] = 1'b1;
    endfunction

endpackage

// File: rtl/regs_wb_fifo.sv
// Small synchronous FIFO holding load results ({addr,data}) until the write port is free.
module regs_wb_fifo
    import regs_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  ld_entry_t din,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output ld_entry_t head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Extra MSB distinguishes full from empty when the index bits match.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    ld_entry_t   mem_q [DEPTH];
    logic        do_push, do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/regs_wb_arb.sv
// Register file write-port arbiter: execute has priority, loads queue in a FIFO,
// and a pending-load scoreboard flags read and write hazards to the core.
module regs_wb_arb
    import regs_pkg::*;
#(
    parameter int unsigned LD_FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exe_we,
    input  logic [REG_AW-1:0] exe_wa,
    input  logic [XLEN-1:0]   exe_wd,
    input  logic              ld_issue,
    input  logic [REG_AW-1:0] ld_issue_a,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [REG_AW-1:0] ld_wa,
    input  logic [XLEN-1:0]   ld_wd,
    input  logic              rs1r,
    input  logic [REG_AW-1:0] rs1a,
    input  logic              rs2r,
    input  logic [REG_AW-1:0] rs2a,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              issue_busy,
    output logic [REG_AW-1:0] rda,
    output logic [XLEN-1:0]   rd,
    output logic              rdw
);

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    ld_entry_t        fifo_head;
    logic             exe_sel, ld_acc, bypass;
    logic             rdw_d, rdw_q;
    reg_addr_t        rda_d, rda_q;
    xword_t           rd_d, rd_q;
    logic [NREGS-1:0] pend_d, pend_q, set_vec, clr_vec;

    regs_wb_fifo #(
        .DEPTH (LD_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   ({ld_wa, ld_wd}),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign ld_ready  = !fifo_full;
    assign exe_sel   = exe_we && (exe_wa != '0);
    assign ld_acc    = ld_valid && ld_ready;
    assign fifo_pop  = !exe_sel && !fifo_empty;
    assign bypass    = !exe_sel && fifo_empty && ld_acc;
    assign fifo_push = ld_acc && !bypass;

    // Write select; loads to x0 are consumed but never reach the write port.
    always_comb begin
        rdw_d   = 1'b0;
        rda_d   = rda_q;
        rd_d    = rd_q;
        clr_vec = '0;
        if (exe_sel) begin
            rdw_d = 1'b1;
            rda_d = exe_wa;
            rd_d  = exe_wd;
        end else if (fifo_pop) begin
            if (fifo_head.addr != '0) begin
                rdw_d   = 1'b1;
                rda_d   = fifo_head.addr;
                rd_d    = fifo_head.data;
                clr_vec = reg_onehot(fifo_head.addr);
            end
        end else if (bypass) begin
            if (ld_wa != '0) begin
                rdw_d   = 1'b1;
                rda_d   = ld_wa;
                rd_d    = ld_wd;
                clr_vec = reg_onehot(ld_wa);
            end
        end
    end

    always_comb begin
        set_vec = '0;
        if (ld_issue && (ld_issue_a != '0)) begin
            set_vec = reg_onehot(ld_issue_a);
        end
        pend_d = (pend_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdw_q  <= 1'b0;
            rda_q  <= '0;
            rd_q   <= '0;
            pend_q <= '0;
        end else begin
            rdw_q  <= rdw_d;
            rda_q  <= rda_d;
            rd_q   <= rd_d;
            pend_q <= pend_d;
        end
    end

    assign rdw        = rdw_q;
    assign rda        = rda_q;
    assign rd         = rd_q;
    assign rs1_busy   = rs1r && (rs1a != '0) && pend_q[rs1a];
    assign rs2_busy   = rs2r && (rs2a != '0) && pend_q[rs2a];
    assign issue_busy = pend_q[ld_issue_a] || (exe_we && pend_q[exe_wa]);

endmodule

// File: tb/tb_regs_wb_arb.sv
// Directed bench for regs_wb_arb: a vector table plus hand sequences for back-pressure and reset.
module tb_regs_wb_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exe_we, ld_issue, ld_valid, rs1r, rs2r;
    logic [4:0]  exe_wa, ld_issue_a, ld_wa, rs1a, rs2a, rda;
    logic [31:0] exe_wd, ld_wd, rd;
    logic        ld_ready, rs1_busy, rs2_busy, issue_busy, rdw;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regs_wb_arb #(
        .LD_FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .exe_we     (exe_we),
        .exe_wa     (exe_wa),
        .exe_wd     (exe_wd),
        .ld_issue   (ld_issue),
        .ld_issue_a (ld_issue_a),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_wa      (ld_wa),
        .ld_wd      (ld_wd),
        .rs1r       (rs1r),
        .rs1a       (rs1a),
        .rs2r       (rs2r),
        .rs2a       (rs2a),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .issue_busy (issue_busy),
        .rda        (rda),
        .rd         (rd),
        .rdw        (rdw)
    );

    typedef struct {
        logic        exe_we;
        logic [4:0]  exe_wa;
        logic [31:0] exe_wd;
        logic        ld_issue;
        logic [4:0]  ld_issue_a;
        logic        ld_valid;
        logic [4:0]  ld_wa;
        logic [31:0] ld_wd;
        logic        rs1r;
        logic [4:0]  rs1a;
        logic        rs2r;
        logic [4:0]  rs2a;
        logic        e_ready, e_rs1b, e_rs2b, e_ibusy;
        logic        e_rdw;
        logic [4:0]  e_rda;
        logic [31:0] e_rd;
    } vec_t;

    function automatic vec_t mk(
        input logic ew, input logic [4:0] ea, input logic [31:0] ed,
        input logic li, input logic [4:0] lia,
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
        input logic xr, input logic x1, input logic x2, input logic xi,
        input logic xw, input logic [4:0] xa, input logic [31:0] xd);
        vec_t v;
        v.exe_we = ew;  v.exe_wa = ea;  v.exe_wd = ed;
        v.ld_issue = li; v.ld_issue_a = lia;
        v.ld_valid = lv; v.ld_wa = la;  v.ld_wd = ld;
        v.rs1r = r1; v.rs1a = a1; v.rs2r = r2; v.rs2a = a2;
        v.e_ready = xr; v.e_rs1b = x1; v.e_rs2b = x2; v.e_ibusy = xi;
        v.e_rdw = xw; v.e_rda = xa; v.e_rd = xd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        exe_we = 0; exe_wa = 0; exe_wd = 0; ld_issue = 0; ld_issue_a = 0;
        ld_valid = 0; ld_wa = 0; ld_wd = 0; rs1r = 0; rs1a = 0; rs2r = 0; rs2a = 0;
    endtask

    // Entered at posedge+1: drive, check comb outputs, step one edge, check write port.
    task automatic apply(input vec_t v, input string nm);
        exe_we = v.exe_we; exe_wa = v.exe_wa; exe_wd = v.exe_wd;
        ld_issue = v.ld_issue; ld_issue_a = v.ld_issue_a;
        ld_valid = v.ld_valid; ld_wa = v.ld_wa; ld_wd = v.ld_wd;
        rs1r = v.rs1r; rs1a = v.rs1a; rs2r = v.rs2r; rs2a = v.rs2a;
        #1;
        chk($sformatf("%s comb{ready,rs1b,rs2b,ibusy}", nm),
            {60'd0, ld_ready, rs1_busy, rs2_busy, issue_busy},
            {60'd0, v.e_ready, v.e_rs1b, v.e_rs2b, v.e_ibusy});
        @(posedge clk);
        #1;
        if (v.e_rdw) begin
            chk($sformatf("%s wb{rdw,rda,rd}", nm), {26'd0, rdw, rda, rd},
                {26'd0, 1'b1, v.e_rda, v.e_rd});
        end else begin
            chk($sformatf("%s rdw", nm), {63'd0, rdw}, 64'd0);
        end
    endtask

    vec_t tbl [17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        //          ew ea     ed          li lia lv la     ld          r1 a1 r2 a2  rdy b1 b2 ib  w  a  d
        tbl[0]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 32'h0);
        tbl[1]  = mk(1, 5, 32'hA5A5A5A5, 0, 0, 1, 6, 32'h11,   0, 0, 0, 0,  1, 0, 0, 0,  1, 5, 32'hA5A5A5A5);
        tbl[2]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    0, 0, 0, 0,  1, 0, 0, 0,  1, 6, 32'h11);
        tbl[3]  = mk(0, 0, 32'h0,        1, 7, 0, 0, 32'h0,    0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 32'h0);
        tbl[4]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    1, 7, 0, 7,  1, 1, 0, 0,  0, 0, 32'h0);
        tbl[5]  = mk(0, 0, 32'h0,        0, 0, 1, 7, 32'h77,   1, 7, 0, 0,  1, 1, 0, 0,  1, 7, 32'h77);
        tbl[6]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    1, 7, 0, 0,  1, 0, 0, 0,  0, 0, 32'h0);
        tbl[7]  = mk(1, 0, 32'hFFFF,     0, 0, 1, 0, 32'h1234, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 32'h0);
        tbl[8]  = mk(0, 0, 32'h0,        0, 0, 1, 8, 32'h88,   0, 0, 0, 0,  1, 0, 0, 0,  1, 8, 32'h88);
        tbl[9]  = mk(0, 0, 32'h0,        1, 0, 0, 0, 32'h0,    0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 32'h0);
        tbl[10] = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    1, 0, 1, 0,  1, 0, 0, 0,  0, 0, 32'h0);
        tbl[11] = mk(0, 0, 32'h0,        1, 9, 0, 0, 32'h0,    0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 32'h0);
        tbl[12] = mk(1, 9, 32'h99,       0, 3, 0, 0, 32'h0,    0, 0, 0, 0,  1, 0, 0, 1,  1, 9, 32'h99);
        tbl[13] = mk(0, 0, 32'h0,        1, 9, 1, 9, 32'h9009, 0, 0, 1, 9,  1, 0, 1, 1,  1, 9, 32'h9009);
        tbl[14] = mk(0, 0, 32'h0,        0, 9, 0, 0, 32'h0,    1, 9, 1, 9,  1, 1, 1, 1,  0, 0, 32'h0);
        tbl[15] = mk(0, 0, 32'h0,        0, 0, 1, 9, 32'h5,    0, 0, 0, 0,  1, 0, 0, 0,  1, 9, 32'h5);
        tbl[16] = mk(0, 0, 32'h0,        0, 9, 0, 0, 32'h0,    1, 9, 0, 0,  1, 0, 0, 0,  0, 0, 32'h0);

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset wb{rdw,rda,rd}", {26'd0, rdw, rda, rd}, 64'd0);
        chk("reset comb{ready,rs1b,rs2b,ibusy}",
            {60'd0, ld_ready, rs1_busy, rs2_busy, issue_busy}, {60'd0, 4'b1000});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Execute held every cycle: loads back up, ready drops at two, then retire in order.
        apply(mk(1, 1, 32'h101, 0, 0, 1, 10, 32'hA, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h101), "bp_a");
        apply(mk(1, 2, 32'h102, 0, 0, 1, 11, 32'hB, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2, 32'h102), "bp_b");
        apply(mk(1, 3, 32'h103, 0, 0, 1, 12, 32'hC, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h103), "bp_c");
        apply(mk(1, 4, 32'h104, 0, 0, 1, 12, 32'hC, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h104), "bp_d");
        apply(mk(0, 0, 32'h0,   0, 0, 1, 12, 32'hC, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 32'hA), "bp_e");
        apply(mk(0, 0, 32'h0,   0, 0, 1, 12, 32'hC, 0, 0, 0, 0, 1, 0, 0, 0, 1, 11, 32'hB), "bp_f");
        apply(mk(0, 0, 32'h0,   0, 0, 0, 0,  32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 12, 32'hC), "bp_g");
        apply(mk(0, 0, 32'h0,   0, 0, 0, 0,  32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  32'h0), "bp_h");

        // Fill the FIFO and mark x4 pending, then reset asynchronously mid-cycle.
        apply(mk(1, 1, 32'h201, 1, 4, 1, 13, 32'hD, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h201), "rst_a");
        apply(mk(1, 2, 32'h202, 0, 0, 1, 14, 32'hE, 1, 4, 0, 0, 1, 1, 0, 0, 1, 2, 32'h202), "rst_b");
        idle_inputs();
        exe_we = 1; exe_wa = 3; exe_wd = 32'h203;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst wb{rdw,rda,rd}", {26'd0, rdw, rda, rd}, 64'd0);
        chk("midrst ready", {63'd0, ld_ready}, 64'd1);
        rs1r = 1; rs1a = 4;
        #1;
        chk("midrst pend cleared", {63'd0, rs1_busy}, 64'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst fifo empty rdw", {63'd0, rdw}, 64'd0);
        chk("postrst ready", {63'd0, ld_ready}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
